// File: rtl/rom_rd_pkg.sv
// rom_rd_pkg: shared size enum, response struct, FIFO depth and alignment helper for rom_rd_ctrl
package rom_rd_pkg;
  localparam int ROM_RD_FIFO_DEPTH = 2;
  typedef enum logic [1:0] {SZ_1B, SZ_2B, SZ_4B, SZ_8B} rom_rd_size_t;
  typedef struct packed {
    logic [63:0] data;
    logic [3:0] id;
    logic err;
  } rom_rd_resp_t;
  function automatic logic misaligned(input logic [2:0] off, input rom_rd_size_t sz);
    return (off & ((3'd1 << sz) - 3'd1)) != 3'd0;
  endfunction
endpackage

// File: rtl/rom_rd_ctrl_if.sv
// rom_rd_ctrl_if: request, ROM and response signals; slave = controller view, master = requester/ROM view
interface rom_rd_ctrl_if #(parameter int abits = 16, parameter int baddr_bits = 32);
  logic i_req_valid;
  logic o_req_ready;
  logic [baddr_bits-1:0] i_req_addr;
  logic [1:0] i_req_size;
  logic [3:0] i_req_id;
  logic [abits-1:0] o_rom_addr;
  logic [63:0] i_rom_rdata;
  logic o_resp_valid;
  logic i_resp_ready;
  logic [63:0] o_resp_data;
  logic [3:0] o_resp_id;
  logic o_resp_err;
  modport slave (
    input i_req_valid, i_req_addr, i_req_size, i_req_id, i_rom_rdata, i_resp_ready,
    output o_req_ready, o_rom_addr, o_resp_valid, o_resp_data, o_resp_id, o_resp_err
  );
  modport master (
    output i_req_valid, i_req_addr, i_req_size, i_req_id, i_rom_rdata, i_resp_ready,
    input o_req_ready, o_rom_addr, o_resp_valid, o_resp_data, o_resp_id, o_resp_err
  );
endinterface

// File: rtl/rom_rd_fifo.sv
// rom_rd_fifo: 2-entry response FIFO; clk/rst, push/din in, pop in, dout/count/empty/full out
module rom_rd_fifo import rom_rd_pkg::*; (
  input logic clk,
  input logic rst,
  input logic push,
  input rom_rd_resp_t din,
  input logic pop,
  output rom_rd_resp_t dout,
  output logic [1:0] count,
  output logic empty,
  output logic full
);
  rom_rd_resp_t mem [ROM_RD_FIFO_DEPTH];
  logic wp, rp, do_push, do_pop;
  assign empty = count == 2'd0;
  assign full = count == 2'(ROM_RD_FIFO_DEPTH);
  assign do_pop = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign dout = mem[rp];
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= din;
  always_ff @(posedge clk)
    if (rst) begin
      wp <= 1'b0;
      rp <= 1'b0;
      count <= 2'd0;
    end else begin
      if (do_push) wp <= !wp;
      if (do_pop) rp <= !rp;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
endmodule

// File: rtl/rom_rd_ctrl.sv
// rom_rd_ctrl: sized ROM read front end; i_clk/i_rst plus slave bus (req in, ROM addr/rdata, resp out); ROM_RD_RANGE_CHK_EN adds upper-address range errors
module rom_rd_ctrl import rom_rd_pkg::*; #(
  parameter int abits = 16,
  parameter int log2_dbytes = 3,
  parameter int baddr_bits = 32
) (
  input logic i_clk,
  input logic i_rst,
  rom_rd_ctrl_if.slave bus
);
  logic acc, s1_valid, s1_err, range_err, pop, fifo_empty, fifo_full, unused;
  logic [3:0] s1_id;
  logic [2:0] s1_off;
  logic [1:0] fifo_count;
  logic [abits-1:0] rom_addr_q;
  logic [63:0] shifted, mask;
  rom_rd_size_t s1_size, req_size;
  rom_rd_resp_t s1_resp, head;
  generate
    if (log2_dbytes != 3) begin : g_bad_dbytes
      $error("rom_rd_ctrl supports only log2_dbytes=3");
    end
  endgenerate
`ifdef ROM_RD_RANGE_CHK_EN
  assign range_err = (bus.i_req_addr >> abits) != '0;
`else
  assign range_err = 1'b0;
`endif
  assign unused = ^{fifo_full, bus.i_req_addr};
  assign req_size = rom_rd_size_t'(bus.i_req_size);
  assign pop = bus.o_resp_valid && bus.i_resp_ready;
  assign bus.o_req_ready = !i_rst && ((fifo_count + {1'b0, s1_valid}) < 2'd2 || pop);
  assign acc = bus.i_req_valid && bus.o_req_ready;
  assign bus.o_rom_addr = acc ? {bus.i_req_addr[abits-1:3], 3'b0} : rom_addr_q;
  always_ff @(posedge i_clk)
    if (i_rst) begin
      s1_valid <= 1'b0;
      rom_addr_q <= '0;
      s1_id <= 4'd0;
      s1_off <= 3'd0;
      s1_size <= SZ_1B;
      s1_err <= 1'b0;
    end else begin
      s1_valid <= acc;
      if (acc) begin
        rom_addr_q <= bus.o_rom_addr;
        s1_id <= bus.i_req_id;
        s1_off <= bus.i_req_addr[2:0];
        s1_size <= req_size;
        s1_err <= range_err || misaligned(bus.i_req_addr[2:0], req_size);
      end
    end
  always_comb begin
    shifted = bus.i_rom_rdata >> {s1_off, 3'b0};
    mask = s1_size == SZ_1B ? 64'hff :
           s1_size == SZ_2B ? 64'hffff :
           s1_size == SZ_4B ? 64'hffff_ffff : '1;
    s1_resp = '{data: s1_err ? 64'd0 : shifted & mask, id: s1_id, err: s1_err};
  end
  rom_rd_fifo u_fifo (
    .clk(i_clk),
    .rst(i_rst),
    .push(s1_valid),
    .din(s1_resp),
    .pop(pop),
    .dout(head),
    .count(fifo_count),
    .empty(fifo_empty),
    .full(fifo_full)
  );
  assign bus.o_resp_valid = !fifo_empty;
  assign bus.o_resp_data = fifo_empty ? 64'd0 : head.data;
  assign bus.o_resp_id = fifo_empty ? 4'd0 : head.id;
  assign bus.o_resp_err = !fifo_empty && head.err;
endmodule

// File: tb/tb_rom_rd_ctrl.sv
// tb_rom_rd_ctrl: directed self-checking bench for rom_rd_ctrl with a 1-cycle ROM model
module tb_rom_rd_ctrl;
  import rom_rd_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  int cyc = 0;
  rom_rd_resp_t got_q[$];
  int got_cyc[$];
  always #5 clk = ~clk;
  rom_rd_ctrl_if #(.abits(16), .baddr_bits(32)) bus();
  rom_rd_ctrl #(.abits(16), .log2_dbytes(3), .baddr_bits(32)) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus(bus)
  );
  function automatic logic [63:0] rom_word(input logic [15:0] a);
    return a[15:3] == 13'd2 ? 64'h8877665544332211 : {8{a[10:3] ^ 8'hC3}};
  endfunction
  always @(posedge clk) begin
    cyc <= cyc + 1;
    bus.i_rom_rdata <= rom_word(bus.o_rom_addr);
  end
  always @(negedge clk)
    if (!rst && bus.o_resp_valid && bus.i_resp_ready) begin
      got_q.push_back('{data: bus.o_resp_data, id: bus.o_resp_id, err: bus.o_resp_err});
      got_cyc.push_back(cyc);
    end
  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic issue(input logic [31:0] a, input logic [1:0] sz, input logic [3:0] id, output int stalls);
    stalls = 0;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b1;
    bus.i_req_addr = a;
    bus.i_req_size = sz;
    bus.i_req_id = id;
    @(negedge clk);
    while (!bus.o_req_ready && stalls < 50) begin
      stalls++;
      @(negedge clk);
    end
    if (!bus.o_req_ready) begin
      checks++;
      failures++;
      $display("FAIL issue_timeout ready=%0b required=1", bus.o_req_ready);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      bus.i_req_valid = 1'b0;
    end
  endtask

  task automatic wait_resps(input int n);
    int t;
    t = 0;
    while (got_q.size() < n && t < 200) begin
      @(negedge clk);
      t++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    bus.i_req_valid = 1'b1;
    bus.i_req_addr = 32'h18;
    repeat (2) @(negedge clk);
    checks++; if (bus.o_req_ready !== 1'b0) begin failures++; $display("FAIL reset_ready got=%0b exp=0", bus.o_req_ready); end
    checks++; if (bus.o_resp_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0b exp=0", bus.o_resp_valid); end
    checks++; if (bus.o_resp_data !== 64'd0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.o_resp_data); end
    checks++; if (bus.o_resp_id !== 4'd0) begin failures++; $display("FAIL reset_id got=%0d exp=0", bus.o_resp_id); end
    checks++; if (bus.o_resp_err !== 1'b0) begin failures++; $display("FAIL reset_err got=%0b exp=0", bus.o_resp_err); end
    checks++; if (bus.o_rom_addr !== 16'h0) begin failures++; $display("FAIL reset_rom_addr got=%h exp=0", bus.o_rom_addr); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_req_valid = 1'b0;
    @(negedge clk);
    checks++; if (bus.o_req_ready !== 1'b1) begin failures++; $display("FAIL post_reset_ready got=%0b exp=1", bus.o_req_ready); end
  endtask

  task automatic test_full_word;
    got_q.delete();
    bus.i_resp_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b1;
    bus.i_req_addr = 32'h10;
    bus.i_req_size = 2'd3;
    bus.i_req_id = 4'd5;
    @(negedge clk);
    checks++; if (bus.o_req_ready !== 1'b1) begin failures++; $display("FAIL full_ready got=%0b exp=1", bus.o_req_ready); end
    checks++; if (bus.o_rom_addr !== 16'h10) begin failures++; $display("FAIL full_rom_addr got=%h exp=0010", bus.o_rom_addr); end
    @(posedge clk);
    #1;
    bus.i_req_valid = 1'b0;
    bus.i_req_addr = 32'h38;
    @(negedge clk);
    checks++; if (bus.o_resp_valid !== 1'b0) begin failures++; $display("FAIL full_early_valid got=%0b exp=0", bus.o_resp_valid); end
    checks++; if (bus.o_rom_addr !== 16'h10) begin failures++; $display("FAIL full_addr_hold got=%h exp=0010", bus.o_rom_addr); end
    @(negedge clk);
    checks++; if (bus.o_resp_valid !== 1'b1) begin failures++; $display("FAIL full_valid got=%0b exp=1", bus.o_resp_valid); end
    checks++; if (bus.o_resp_data !== 64'h8877665544332211) begin failures++; $display("FAIL full_data got=%h exp=8877665544332211", bus.o_resp_data); end
    checks++; if (bus.o_resp_id !== 4'd5) begin failures++; $display("FAIL full_id got=%0d exp=5", bus.o_resp_id); end
    checks++; if (bus.o_resp_err !== 1'b0) begin failures++; $display("FAIL full_err got=%0b exp=0", bus.o_resp_err); end
    @(negedge clk);
    checks++; if (bus.o_resp_valid !== 1'b0) begin failures++; $display("FAIL full_popped got=%0b exp=0", bus.o_resp_valid); end
  endtask

  task automatic test_sub_word;
    int s;
    got_q.delete();
    issue(32'h13, 2'd0, 4'd1, s);
    issue(32'h14, 2'd2, 4'd2, s);
    idle(1);
    wait_resps(2);
    checks++;
    if (got_q.size() != 2) begin failures++; $display("FAIL sub_count got=%0d exp=2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== '{data: 64'h44, id: 4'd1, err: 1'b0}) begin failures++; $display("FAIL sub_byte got=%h/%0d/%0b exp=44/1/0", got_q[0].data, got_q[0].id, got_q[0].err); end
      checks++; if (got_q[1] !== '{data: 64'h88776655, id: 4'd2, err: 1'b0}) begin failures++; $display("FAIL sub_word got=%h/%0d/%0b exp=88776655/2/0", got_q[1].data, got_q[1].id, got_q[1].err); end
    end
  endtask

  task automatic test_misaligned;
    int s;
    got_q.delete();
    issue(32'h12, 2'd2, 4'd3, s);
    issue(32'h10, 2'd1, 4'd4, s);
    idle(1);
    wait_resps(2);
    checks++;
    if (got_q.size() != 2) begin failures++; $display("FAIL mis_count got=%0d exp=2", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== '{data: 64'h0, id: 4'd3, err: 1'b1}) begin failures++; $display("FAIL mis_err got=%h/%0d/%0b exp=0/3/1", got_q[0].data, got_q[0].id, got_q[0].err); end
      checks++; if (got_q[1] !== '{data: 64'h2211, id: 4'd4, err: 1'b0}) begin failures++; $display("FAIL mis_next got=%h/%0d/%0b exp=2211/4/0", got_q[1].data, got_q[1].id, got_q[1].err); end
    end
  endtask

  task automatic test_back_to_back;
    int s, tot;
    got_q.delete();
    got_cyc.delete();
    tot = 0;
    bus.i_resp_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      issue(32'(i * 8), 2'd3, 4'(i), s);
      tot += s;
    end
    idle(1);
    wait_resps(8);
    checks++; if (tot != 0) begin failures++; $display("FAIL b2b_stalls got=%0d exp=0", tot); end
    checks++;
    if (got_q.size() != 8) begin failures++; $display("FAIL b2b_count got=%0d exp=8", got_q.size()); end
    else
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[i] !== '{data: rom_word(16'(i * 8)), id: 4'(i), err: 1'b0} || got_cyc[i] != got_cyc[0] + i) begin
          failures++;
          $display("FAIL b2b_resp%0d got=%h/%0d/%0b@%0d exp=%h/%0d/0@%0d", i, got_q[i].data, got_q[i].id, got_q[i].err, got_cyc[i], rom_word(16'(i * 8)), i, got_cyc[0] + i);
        end
      end
  endtask

  task automatic test_stall;
    int k;
    rom_rd_resp_t snap;
    got_q.delete();
    bus.i_resp_ready = 1'b0;
    k = 0;
    snap = '0;
    for (int c = 0; c < 80 && got_q.size() < 8; c++) begin
      @(posedge clk);
      #1;
      if (c == 8) bus.i_resp_ready = 1'b1;
      bus.i_req_valid = k < 8;
      bus.i_req_addr = 32'((k + 3) * 8);
      bus.i_req_size = 2'd3;
      bus.i_req_id = 4'(k);
      @(negedge clk);
      if (c == 6) snap = '{data: bus.o_resp_data, id: bus.o_resp_id, err: bus.o_resp_err};
      if (c == 7) begin
        checks++; if (k != 2) begin failures++; $display("FAIL stall_accepts got=%0d exp=2", k); end
        checks++; if (bus.o_req_ready !== 1'b0) begin failures++; $display("FAIL stall_ready got=%0b exp=0", bus.o_req_ready); end
        checks++; if (bus.o_resp_valid !== 1'b1) begin failures++; $display("FAIL stall_valid got=%0b exp=1", bus.o_resp_valid); end
        checks++; if (snap !== '{data: 64'hC0C0C0C0C0C0C0C0, id: 4'd0, err: 1'b0}) begin failures++; $display("FAIL stall_head got=%h/%0d exp=c0c0c0c0c0c0c0c0/0", snap.data, snap.id); end
        checks++; if (bus.o_resp_data !== snap.data || bus.o_resp_id !== snap.id || bus.o_resp_err !== snap.err) begin failures++; $display("FAIL stall_hold got=%h/%0d exp=%h/%0d", bus.o_resp_data, bus.o_resp_id, snap.data, snap.id); end
      end
      if (bus.i_req_valid && bus.o_req_ready) k++;
    end
    idle(5);
    checks++;
    if (got_q.size() != 8) begin failures++; $display("FAIL stall_count got=%0d exp=8", got_q.size()); end
    else
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (got_q[i] !== '{data: rom_word(16'((i + 3) * 8)), id: 4'(i), err: 1'b0}) begin
          failures++;
          $display("FAIL stall_resp%0d got=%h/%0d/%0b exp=%h/%0d/0", i, got_q[i].data, got_q[i].id, got_q[i].err, rom_word(16'((i + 3) * 8)), i);
        end
      end
  endtask

  task automatic test_range;
    int s;
    rom_rd_resp_t exp;
    got_q.delete();
    bus.i_resp_ready = 1'b1;
`ifdef ROM_RD_RANGE_CHK_EN
    exp = '{data: 64'h0, id: 4'd6, err: 1'b1};
`else
    exp = '{data: 64'hC3C3C3C3C3C3C3C3, id: 4'd6, err: 1'b0};
`endif
    issue(32'h0001_0000, 2'd3, 4'd6, s);
    idle(1);
    wait_resps(1);
    checks++;
    if (got_q.size() != 1) begin failures++; $display("FAIL range_count got=%0d exp=1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== exp) begin failures++; $display("FAIL range_resp got=%h/%0d/%0b exp=%h/%0d/%0b", got_q[0].data, got_q[0].id, got_q[0].err, exp.data, exp.id, exp.err); end
    end
  endtask

  task automatic test_reset_mid;
    int s;
    bus.i_resp_ready = 1'b0;
    issue(32'h10, 2'd3, 4'd7, s);
    issue(32'h18, 2'd3, 4'd8, s);
    idle(4);
    @(negedge clk);
    checks++; if (bus.o_resp_valid !== 1'b1 || bus.o_req_ready !== 1'b0) begin failures++; $display("FAIL rstmid_full got=%0b/%0b exp=1/0", bus.o_resp_valid, bus.o_req_ready); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.i_req_valid = 1'b1;
    bus.i_req_addr = 32'h20;
    @(negedge clk);
    checks++; if (bus.o_req_ready !== 1'b0) begin failures++; $display("FAIL rstmid_ready got=%0b exp=0", bus.o_req_ready); end
    @(negedge clk);
    checks++; if (bus.o_resp_valid !== 1'b0) begin failures++; $display("FAIL rstmid_valid got=%0b exp=0", bus.o_resp_valid); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.i_req_valid = 1'b0;
    bus.i_resp_ready = 1'b1;
    got_q.delete();
    issue(32'h10, 2'd3, 4'd9, s);
    idle(1);
    wait_resps(1);
    idle(6);
    checks++;
    if (got_q.size() != 1) begin failures++; $display("FAIL rstmid_count got=%0d exp=1", got_q.size()); end
    else begin
      checks++; if (got_q[0] !== '{data: 64'h8877665544332211, id: 4'd9, err: 1'b0}) begin failures++; $display("FAIL rstmid_resp got=%h/%0d/%0b exp=8877665544332211/9/0", got_q[0].data, got_q[0].id, got_q[0].err); end
    end
  endtask

  initial begin
    bus.i_req_valid = 1'b0;
    bus.i_req_addr = '0;
    bus.i_req_size = 2'd0;
    bus.i_req_id = 4'd0;
    bus.i_resp_ready = 1'b1;
    test_reset();
    test_full_word();
    test_sub_word();
    test_misaligned();
    test_back_to_back();
    test_stall();
    test_range();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
